// File: rtl/eth_mac_1g.sv
// GMII 1G receive front end: captures one frame into a flat byte buffer,
// flags good frames with a one-cycle pulse and echoes RX onto TX.
module eth_mac_1g #(
  parameter int MAX_BYTES = 1518,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           rx_data,
  input  logic                        rx_dv,
  input  logic                        rx_er,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_en,
  output logic                        tx_er,
  output logic [MAX_BYTES*DATA_W-1:0] packet_flat,
  output logic                        packet_valid
);

  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

  typedef enum logic [1:0] {SYNC, IDLE, RECV} state_t;

  state_t      r_state;
  logic [10:0] r_count;
  logic        r_err;
  logic [13:0] w_bitIdx;

  assign w_bitIdx = {r_count, 3'b000};

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_data      <= '0;
      tx_en        <= 1'b0;
      tx_er        <= 1'b0;
      packet_flat  <= '0;
      packet_valid <= 1'b0;
      r_state      <= SYNC;
      r_count      <= '0;
      r_err        <= 1'b0;
    end else begin
      tx_data      <= rx_data;
      tx_en        <= rx_dv;
      tx_er        <= rx_er;
      packet_valid <= 1'b0;
      case (r_state)
        // Wait for a gap so a frame already in flight at reset is never captured.
        SYNC: begin
          if (!rx_dv) r_state <= IDLE;
        end
        IDLE: begin
          if (rx_dv) begin
            packet_flat[DATA_W-1:0] <= rx_data;
            r_count <= 11'd1;
            r_err   <= rx_er;
            r_state <= RECV;
          end
        end
        RECV: begin
          if (rx_dv) begin
            if (r_count < MAX_CNT) begin
              packet_flat[w_bitIdx +: DATA_W] <= rx_data;
              r_count <= r_count + 11'd1;
              r_err   <= r_err | rx_er;
            end else begin
              r_err <= 1'b1;
            end
          end else begin
            packet_valid <= ~r_err;
            r_state      <= IDLE;
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mac_1g.sv
// Self-checking bench for eth_mac_1g: frame-level reference model compared
// every cycle, plus hand-computed byte and pulse expectations.
module tb_eth_mac_1g;

  localparam int MAXB = 1518;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_dv;
  logic              rx_er;
  logic [7:0]        tx_data;
  logic              tx_en;
  logic              tx_er;
  logic [MAXB*8-1:0] packet_flat;
  logic              packet_valid;

  int checkCount = 0;
  int errorCount = 0;
  int pulseCount = 0;
  bit checksOn   = 0;

  // reference model state
  logic [7:0]        expTxData;
  logic              expTxEn;
  logic              expTxEr;
  logic              expValid;
  logic [MAXB*8-1:0] expFlat;
  bit                synced;
  bit                inFrame;
  bit                frameBad;
  int                frameLen;

  eth_mac_1g #(.MAX_BYTES(MAXB), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_dv       (rx_dv),
    .rx_er       (rx_er),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_er       (tx_er),
    .packet_flat (packet_flat),
    .packet_valid(packet_valid)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Single comparison point: counts and reports one check.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] flatByte(input int idx);
    return packet_flat[8*idx +: 8];
  endfunction

  // Frame-level model: a frame is a run of rx_dv cycles; it is good when it
  // fits in the buffer and no byte carried rx_er. Nothing counts until the
  // first quiet cycle after reset.
  always @(posedge clk) begin
    if (!rst) begin
      expTxData = 8'h00;
      expTxEn   = 1'b0;
      expTxEr   = 1'b0;
      expValid  = 1'b0;
      expFlat   = '0;
      synced    = 1'b0;
      inFrame   = 1'b0;
      frameBad  = 1'b0;
      frameLen  = 0;
    end else begin
      expTxData = rx_data;
      expTxEn   = rx_dv;
      expTxEr   = rx_er;
      expValid  = 1'b0;
      if (!synced) begin
        if (!rx_dv) synced = 1'b1;
      end else if (rx_dv) begin
        if (!inFrame) begin
          inFrame  = 1'b1;
          frameLen = 0;
          frameBad = 1'b0;
        end
        if (frameLen < MAXB) expFlat[8*frameLen +: 8] = rx_data;
        frameLen++;
        if (rx_er) frameBad = 1'b1;
      end else if (inFrame) begin
        expValid = !frameBad && (frameLen <= MAXB);
        inFrame  = 1'b0;
      end
    end
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    if (checksOn) begin
      checkOutput("txData", 32'(tx_data), 32'(expTxData));
      checkOutput("txEn", 32'(tx_en), 32'(expTxEn));
      checkOutput("txEr", 32'(tx_er), 32'(expTxEr));
      checkOutput("packetValid", 32'(packet_valid), 32'(expValid));
      checkCount++;
      if (packet_flat !== expFlat) begin
        errorCount++;
        for (int i = 0; i < MAXB; i++) begin
          if (packet_flat[8*i +: 8] !== expFlat[8*i +: 8]) begin
            $display("[TB] FAIL packetFlat byte %0d: actual=%0h expected=%0h",
                     i, packet_flat[8*i +: 8], expFlat[8*i +: 8]);
            break;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (packet_valid === 1'b1) pulseCount++;
  end

  // Drives one frame of the (0xAA+b) pattern, then drops rx_dv; returns on
  // the falling edge where rx_dv was just lowered.
  task automatic applyStimulus(input int len, input bit withErr);
    for (int b = 0; b < len; b++) begin
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_data = 8'(8'hAA + b);
      rx_er   = withErr;
    end
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    rx_er   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    rx_data = 8'h00;
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    @(negedge clk);
    checksOn = 1'b1;
    idleCycles(4);
    rst = 1'b1;

    $display("[TB] reset state");
    checkOutput("resetTxData", 32'(tx_data), 32'h0);
    checkOutput("resetTxEn", 32'(tx_en), 32'h0);
    checkOutput("resetValid", 32'(packet_valid), 32'h0);
    checkOutput("resetFlatZero", 32'(packet_flat == '0), 32'h1);
    idleCycles(2);

    $display("[TB] full-size frame");
    pulseCount = 0;
    applyStimulus(1518, 1'b0);
    checkOutput("pulseNotEarly", 32'(packet_valid), 32'h0);
    @(negedge clk);
    checkOutput("pulseHigh", 32'(packet_valid), 32'h1);
    @(negedge clk);
    checkOutput("pulseLow", 32'(packet_valid), 32'h0);
    checkOutput("fullByte0", 32'(flatByte(0)), 32'hAA);
    checkOutput("fullByte1517", 32'(flatByte(1517)), 32'h97);
    idleCycles(3);
    checkOutput("fullPulses", 32'(pulseCount), 32'd1);

    $display("[TB] short frame over stale buffer");
    pulseCount = 0;
    applyStimulus(64, 1'b0);
    idleCycles(4);
    checkOutput("shortByte63", 32'(flatByte(63)), 32'hE9);
    checkOutput("staleByte64", 32'(flatByte(64)), 32'hEA);
    checkOutput("shortPulses", 32'(pulseCount), 32'd1);

    $display("[TB] reset in mid-frame");
    pulseCount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rx_dv   = 1'b1;
      rx_data = 8'(8'h10 + c);
    end
    @(negedge clk);
    rst = 1'b0;
    idleCycles(5);
    rst = 1'b1;
    idleCycles(6);
    rx_dv = 1'b0;
    idleCycles(5);
    checkOutput("midResetPulses", 32'(pulseCount), 32'd0);
    checkOutput("midResetFlatZero", 32'(packet_flat == '0), 32'h1);
    applyStimulus(64, 1'b0);
    idleCycles(4);
    checkOutput("afterResetByte0", 32'(flatByte(0)), 32'hAA);
    checkOutput("afterResetByte64", 32'(flatByte(64)), 32'h00);
    checkOutput("afterResetPulses", 32'(pulseCount), 32'd1);

    $display("[TB] back-to-back frames");
    pulseCount = 0;
    applyStimulus(10, 1'b0);
    applyStimulus(12, 1'b0);
    idleCycles(4);
    checkOutput("backToBackPulses", 32'(pulseCount), 32'd2);

    $display("[TB] errored frame");
    pulseCount = 0;
    applyStimulus(1518, 1'b1);
    checkOutput("errTxEr", 32'(tx_er), 32'h1);
    idleCycles(10);
    checkOutput("errTxErClear", 32'(tx_er), 32'h0);
    checkOutput("errPulses", 32'(pulseCount), 32'd0);
    checkOutput("errBytesKept", 32'(flatByte(1517)), 32'h97);

    $display("[TB] oversize frame");
    pulseCount = 0;
    applyStimulus(1519, 1'b0);
    idleCycles(5);
    checkOutput("oversizePulses", 32'(pulseCount), 32'd0);
    checkOutput("oversizeLastByte", 32'(flatByte(1517)), 32'h97);

    $display("[TB] three frames");
    pulseCount = 0;
    applyStimulus(100, 1'b0);
    idleCycles(5);
    applyStimulus(200, 1'b0);
    idleCycles(5);
    applyStimulus(300, 1'b0);
    idleCycles(5);
    checkOutput("threePulses", 32'(pulseCount), 32'd3);
    checkOutput("threeByte0", 32'(flatByte(0)), 32'hAA);
    checkOutput("threeByte299", 32'(flatByte(299)), 32'hD5);
    checkOutput("threeByte300Stale", 32'(flatByte(300)), 32'hD6);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/eth_mac_1g.md
Name: eth_mac_1g

Overview:
- GMII-style 1G receive front end. Captures one Ethernet frame of up to 1518 bytes into a flat byte buffer.
- Pulses packet_valid when a good frame ends.
- Echoes the receive stream onto the transmit interface with one cycle of latency.
- Sits between the PHY interface and the packet-processing / accelerator logic, which consumes packet_flat.

Parameters:
- MAX_BYTES, 1518: maximum frame length in bytes; packet_flat width is MAX_BYTES*8 = 12144.
- DATA_W, 8: GMII data width; fixed at 8.

Ports:
- clk  in  1  system clock, 125 MHz; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on a clk edge).
- rx_data  in  8  receive byte.
- rx_dv  in  1  receive data valid; high for the duration of a frame.
- rx_er  in  1  receive error flag.
- tx_data  out  8  transmit byte (registered echo of rx_data).
- tx_en  out  1  transmit enable (registered echo of rx_dv).
- tx_er  out  1  transmit error (registered echo of rx_er).
- packet_flat  out  12144  frame buffer; byte i is at [8*i +: 8]; byte 0 is the first received byte.
- packet_valid  out  1  one-cycle pulse marking the end of a good frame.

Behaviour:
- Reset (rst==0 at a clk edge):
  - tx_data=0, tx_en=0, tx_er=0, packet_valid=0, packet_flat=all zeros.
  - Byte counter=0, error flag=0, state=SYNC.
- TX echo, every cycle outside reset: tx_data<=rx_data, tx_en<=rx_dv, tx_er<=rx_er. Latency is exactly 1 cycle, independent of RX state.
- State machine: SYNC, IDLE, RECV.
  - SYNC: discard input; go to IDLE on the first cycle with rx_dv==0. This prevents a partial frame from being captured after a mid-frame reset.
  - IDLE, rx_dv==1: write rx_data to byte 0; count<=1; err<=rx_er; go to RECV.
  - RECV, rx_dv==1:
    - If count<MAX_BYTES: write rx_data to byte[count] and count<=count+1.
    - Else (count==MAX_BYTES): discard the byte and set err (oversize).
    - err<=err|rx_er.
  - RECV, rx_dv==0: frame ends.
    - If err==0: packet_valid<=1 for exactly one cycle (the cycle after the first rx_dv==0 sample).
    - If err==1: no pulse.
    - Go to IDLE in either case.
- packet_valid is 0 in every cycle except that end-of-frame pulse.
- Buffer writes are registered: the byte sampled at edge N is visible on packet_flat after edge N.
- packet_flat is not cleared between frames.
  - Bytes beyond the current frame length keep stale contents from earlier frames.
  - Consumers use their own length knowledge.
  - Bytes written by an errored frame remain in the buffer.
- A 1-cycle rx_dv gap ends the frame. Back-to-back frames separated by one idle cycle are both captured, each with its own packet_valid pulse.
- Exactly MAX_BYTES bytes is legal (no error). Byte MAX_BYTES+1 sets err.
- Byte counter width: 11 bits; saturates at MAX_BYTES.

Test Plan:
- Reset with rst=0 for 5 cycles, then 1 -> all outputs 0 and packet_flat all zeros. Then 1518-byte frame with byte b=(0xAA+b)&0xFF -> packet_flat[7:0]=0xAA, byte 1517=0x97, packet_valid high for exactly one cycle, one cycle after rx_dv falls.
- 64-byte frame of the same pattern after the 1518-byte frame -> bytes 0..63 overwritten, byte 64 still 0xEA from the previous frame, one packet_valid pulse.
- rx_dv held high 20 cycles, then rst=0 for 5 cycles while rx_dv stays high, then rx_dv drops -> no packet_valid pulse; packet_flat zeros; next frame captured normally.
- 1518-byte frame with rx_er=1 throughout -> tx_er=1 one cycle after each erroneous byte, no packet_valid pulse; tx_er=0 ten cycles after the frame.
- 1519-byte frame -> byte 1518 dropped, no packet_valid pulse.
- Frames of 100, 200 and 300 bytes, each followed by 5 idle cycles -> three packet_valid pulses. After the last frame, bytes 0..299 hold the pattern and byte 0=0xAA. Throughout, tx_data equals rx_data delayed by one cycle and tx_en equals rx_dv delayed by one cycle.
